// File: rtl/imm_pkg.sv
// Shared types for the immediate decode stage: format codes, RV opcodes and the
// pipeline entry carried through the main/skid registers.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Fields sized for the widest legal datapath; narrower builds use the low bits.
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [ENTRY_W-1:0] imm;
    imm_fmt_t           fmt;
    logic [ENTRY_W-1:0] target;
    logic [ENTRY_W-1:0] pc;
  } imm_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational RV immediate extractor: instr -> sign-extended imm and format.
// Optional CSR zimm decode is enabled with IMM_CSR_ZIMM_EN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt
);

  logic [63:0] imm_wide;
  logic        sign;

  assign sign = instr[31];

  always_comb begin
    fmt      = FMT_NONE;
    imm_wide = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt      = FMT_I;
        imm_wide = {{52{sign}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt      = FMT_S;
        imm_wide = {{52{sign}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt      = FMT_B;
        imm_wide = {{51{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt      = FMT_U;
        imm_wide = {{32{sign}}, instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt      = FMT_J;
        imm_wide = {{43{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
`ifdef IMM_CSR_ZIMM_EN
      OP_SYSTEM: begin
        // Only the immediate CSR forms (funct3 101/110/111) carry a zimm.
        if (instr[14] && (instr[13:12] != 2'b00)) begin
          fmt      = FMT_Z;
          imm_wide = {59'b0, instr[19:15]};
        end
      end
`endif
      default: begin
        fmt      = FMT_NONE;
        imm_wide = '0;
      end
    endcase
  end

  assign imm = imm_wide[XLEN-1:0];

  logic unused_bits;
  assign unused_bits = ^imm_wide;

endmodule

// File: rtl/imm_decode_stage.sv
// Pipelined immediate decode at ID->EX: decode + target add, then a main/skid
// register pair for full-throughput handshaking. Optional macro: IMM_CSR_ZIMM_EN.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [PC_W-1:0] out_target,
  output logic [PC_W-1:0] out_pc
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t     state_reg, state_next;
  imm_entry_t m_reg, m_next, s_reg, s_next, in_entry;

  logic [XLEN-1:0] ext_imm;
  imm_fmt_t        ext_fmt;
  logic [63:0]     pc_wide, imm_wide, sum_wide;
  logic            in_acc, out_fire;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (in_instr),
    .imm   (ext_imm),
    .fmt   (ext_fmt)
  );

  always_comb begin
    pc_wide              = '0;
    pc_wide[PC_W-1:0]    = in_pc;
    imm_wide             = {64{ext_imm[XLEN-1]}};
    imm_wide[XLEN-1:0]   = ext_imm;
    sum_wide             = pc_wide + imm_wide;
    in_entry.imm         = imm_wide;
    in_entry.fmt         = ext_fmt;
    in_entry.pc          = pc_wide;
    // A zimm is not an offset, so the target stays at pc for that format.
    in_entry.target      = pc_wide;
    if (ext_fmt != FMT_Z) begin
      in_entry.target            = '0;
      in_entry.target[PC_W-1:0]  = sum_wide[PC_W-1:0];
    end
  end

  assign in_ready  = (state_reg != ST_FULL);
  assign out_valid = (state_reg != ST_EMPTY);
  assign in_acc    = in_valid && in_ready && !flush;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    s_next     = s_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (in_acc) begin
          m_next     = in_entry;
          state_next = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_acc && out_fire) begin
          m_next = in_entry;
        end else if (in_acc) begin
          s_next     = in_entry;
          state_next = ST_FULL;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          m_next     = s_reg;
          state_next = ST_ONE;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      m_reg     <= '0;
      s_reg     <= '0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      s_reg     <= s_next;
    end
  end

  assign out_imm    = m_reg.imm[XLEN-1:0];
  assign out_fmt    = m_reg.fmt;
  assign out_target = m_reg.target[PC_W-1:0];
  assign out_pc     = m_reg.pc[PC_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{m_reg.imm, m_reg.target, m_reg.pc, sum_wide};

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: 32-bit instance for handshake/flush/reset
// plus a 64-bit instance fed the same stream for sign-extension checks.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [63:0] in_pc64;

  logic        in_ready, out_valid;
  logic [31:0] out_imm, out_target, out_pc;
  logic [2:0]  out_fmt;

  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign in_pc64 = {32'b0, in_pc};

  imm_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target), .out_pc(out_pc)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_target(out_target64), .out_pc(out_pc64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one entry for one clock, then check the single-cycle result on dut.
  task automatic test_single(input string name, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] exp_imm, input logic [2:0] exp_fmt,
                             input logic [31:0] exp_tgt);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s valid got %0b exp 1", name, out_valid); end
    checks++; if (out_imm !== exp_imm) begin errors++; $display("FAIL %s imm got %h exp %h", name, out_imm, exp_imm); end
    checks++; if (out_fmt !== exp_fmt) begin errors++; $display("FAIL %s fmt got %0d exp %0d", name, out_fmt, exp_fmt); end
    checks++; if (out_target !== exp_tgt) begin errors++; $display("FAIL %s target got %h exp %h", name, out_target, exp_tgt); end
    checks++; if (out_pc !== pc) begin errors++; $display("FAIL %s pc got %h exp %h", name, out_pc, pc); end
    $display("txn %s instr=%h pc=%h imm=%h fmt=%0d target=%h", name, instr, pc, out_imm, out_fmt, out_target);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s drain got %0b exp 0", name, out_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h10; out_ready = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
    checks++; if ({out_imm, out_fmt, out_target, out_pc} !== 99'd0) begin errors++;
      $display("FAIL reset_payload got imm=%h fmt=%0d tgt=%h pc=%h exp 0", out_imm, out_fmt, out_target, out_pc); end
    $display("txn reset out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  task automatic test_formats();
    test_single("addi",  32'hFFF00093, 32'h0,    32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF);
    test_single("beq",   32'hFE000EE3, 32'h100,  32'hFFFFFFFC, 3'd3, 32'h000000FC);
    test_single("sw",    32'h00112623, 32'h200,  32'h0000000C, 3'd2, 32'h0000020C);
    test_single("jal",   32'h008000EF, 32'h1000, 32'h00000008, 3'd5, 32'h00001008);
    test_single("auipc", 32'h12345097, 32'h10,   32'h12345000, 3'd4, 32'h12345010);
    test_single("none",  32'h0000007F, 32'h44,   32'h0,        3'd0, 32'h44);
`ifdef IMM_CSR_ZIMM_EN
    test_single("csrrwi", 32'h3401D073, 32'h80,  32'h3,        3'd6, 32'h80);
`else
    test_single("csrrwi", 32'h3401D073, 32'h80,  32'h0,        3'd0, 32'h80);
`endif
  endtask

  task automatic test_xlen64();
    in_valid = 1'b1; in_instr = 32'h800000B7; in_pc = 32'h0; out_ready = 1'b1;
    tick();
    in_instr = 32'h0000007F; in_pc = 32'h48;
    checks++; if (out_imm64 !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL lui64_imm got %h exp ffffffff80000000", out_imm64); end
    checks++; if (out_fmt64 !== 3'd4) begin errors++; $display("FAIL lui64_fmt got %0d exp 4", out_fmt64); end
    checks++; if (out_imm !== 32'h80000000) begin errors++; $display("FAIL lui32_imm got %h exp 80000000", out_imm); end
    $display("txn lui64 imm=%h fmt=%0d", out_imm64, out_fmt64);
    tick();
    in_valid = 1'b0;
    checks++; if (out_fmt64 !== 3'd0 || out_imm64 !== 64'd0) begin errors++; $display("FAIL none64 got fmt=%0d imm=%h exp 0/0", out_fmt64, out_imm64); end
    checks++; if (out_target64 !== 64'h48) begin errors++; $display("FAIL none64_target got %h exp 48", out_target64); end
    $display("txn none64 imm=%h target=%h", out_imm64, out_target64);
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h0;
    tick();
    in_instr = 32'h00200093;
    checks++; if (out_imm !== 32'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_0 got imm=%h rdy=%0b exp 1/1", out_imm, in_ready); end
    tick();
    in_instr = 32'h00300093;
    checks++; if (out_imm !== 32'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_1 got imm=%h rdy=%0b exp 2/1", out_imm, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_imm !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_2 got imm=%h vld=%0b exp 3/1", out_imm, out_valid); end
    $display("txn back_to_back last imm=%h", out_imm);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    tick();
    in_instr = 32'h00A00113;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %0b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %0b exp 0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1 || out_imm !== 32'd5) begin errors++; $display("FAIL bp_hold%0d got vld=%0b imm=%h exp 1/5", i, out_valid, out_imm); end
      tick();
    end
    out_ready = 1'b1;
    checks++; if (out_imm !== 32'd5) begin errors++; $display("FAIL bp_first got %h exp 5", out_imm); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_imm !== 32'd10) begin errors++; $display("FAIL bp_second got vld=%0b imm=%h exp 1/a", out_valid, out_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_nodup got %0b exp 0", out_valid); end
    $display("txn backpressure two entries delivered");
  endtask

  task automatic fill_full();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    tick();
    in_instr = 32'h00A00113;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    fill_full();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full got vld=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700093;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %0b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_late got %0b exp 0", out_valid); end
    $display("txn flush state empty");
  endtask

  task automatic test_reset_midstream();
    fill_full();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got vld=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
    checks++; if ({out_imm, out_fmt, out_target, out_pc} !== 99'd0) begin errors++;
      $display("FAIL rst_mid_payload got imm=%h fmt=%0d tgt=%h pc=%h exp 0", out_imm, out_fmt, out_target, out_pc); end
    $display("txn reset_midstream out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Parametrised, pipelined successor to the combinational immediate generator; sits at the ID->EX boundary.
- Accepts one instruction and its PC per handshake and classifies the immediate format.
- Produces the XLEN-wide sign-extended immediate plus a precomputed PC-relative target.
- Registered output with a 2-entry skid buffer gives full throughput under backpressure; supports pipeline flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PC_W, XLEN, width of pc input and target output.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  discard all held entries (branch mispredict or trap).
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_W  instruction address.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  imm_fmt_t format code.
- out_target  output  PC_W  pc + imm, modulo 2^PC_W.
- out_pc  output  PC_W  passthrough pc.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, in_ready=1 from the next cycle.
  - out_imm, out_fmt, out_target, out_pc = 0.
  - Both skid entries are invalidated.
  - Reset wins over flush and over any handshake in the same cycle.
- Handshakes:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Payload is stable while out_valid && !out_ready.
- Latency: an accepted entry appears on the outputs in the next cycle (1 cycle).
- Storage: main register M plus skid register S. States are EMPTY (M,S empty), ONE (M full), FULL (M,S full).
  - EMPTY: accept -> ONE.
  - ONE, accept and out-transfer -> ONE with the new entry.
  - ONE, accept without out-transfer -> FULL; the new entry goes to S.
  - ONE, out-transfer only -> EMPTY.
  - FULL: out-transfer moves S to M -> ONE.
- in_ready = !S_valid. It is registered, not combinationally dependent on out_ready.
- flush:
  - Next cycle: state EMPTY, out_valid=0, in_ready=1.
  - An in-transfer in the flush cycle is discarded.
  - An out-transfer in the flush cycle still completes.
- Format decode (opcode = instr[6:0]):
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Otherwise NONE, with imm=0 and target=pc.
- Immediate bit fields are standard RV. All formats sign-extend from instr[31] to XLEN; U is sign-extended from bit 31 when XLEN=64.
- out_target = pc + imm, truncated to PC_W. It is computed for every format; consumers use it only for B, J and AUIPC.
- Decode and add happen before the register; there is no combinational path from in_* to out_*.

Optional Feature:
- Macro IMM_CSR_ZIMM_EN.
- When defined:
  - Opcode 1110011 with funct3 in {101,110,111} decodes as fmt Z.
  - imm = zero-extended instr[19:15] (5-bit zimm).
  - target = pc.
- When undefined, opcode 1110011 decodes as NONE. Encoding 6 is still reserved in the package.

Decomposition:
- Package imm_pkg holds:
  - enum imm_fmt_t (3 bits): NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
  - opcode localparams OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM.
  - struct imm_entry_t {imm, fmt, target, pc}.
- Sub-module imm_extract: purely combinational, instr -> {imm, fmt}, parametrised by XLEN. It is instantiated once ahead of the target adder.

Test Plan:
- ADDI 0xFFF00093, pc=0x0, out_ready=1 -> one cycle later out_valid=1, imm=0xFFFFFFFF, fmt=I, target=0xFFFFFFFF.
- BEQ 0xFE000EE3, pc=0x100 -> imm=0xFFFFFFFC, fmt=B, target=0x000000FC.
- XLEN=64, LUI 0x800000B7 -> imm=0xFFFFFFFF80000000, fmt=U; opcode 0x0000007F -> fmt=NONE, imm=0, target=pc.
- Backpressure: two back-to-back entries with out_ready=0 for 3 cycles:
  - in_ready drops the cycle after the second accept.
  - Both entries are delivered in order once out_ready=1, with no duplication.
  - in_ready returns to 1 one cycle after S drains.
- Flush while FULL -> next cycle out_valid=0, in_ready=1; an in-transfer in the flush cycle never appears.
- rst_n=0 for one cycle mid-stream with FULL state -> all outputs 0 and in_ready=1 the next cycle. With IMM_CSR_ZIMM_EN, CSRRWI 0x3401D073 -> fmt=Z, imm=0x3.
